// File: rtl/vga_scanout.sv
// VGA timing generator and two-stage scanout pipeline: counters address a cell-based
// video memory, and the returned cell colour is emitted two pixel ticks later with matching syncs.
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CELL_W    = 16,
  parameter int CELL_H    = 8,
  parameter int COLS      = 40
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iPixelTick,
  output logic [11:0] oRamAddress,
  input  logic [2:0]  iRamData,
  output logic        oRed,
  output logic        oGreen,
  output logic        oBlue,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oVisible,
  output logic        oFrameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SS     = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SE     = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] CELL_W_H = HW'(CELL_W);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SS     = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SE     = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] CELL_H_V = VW'(CELL_H);
  localparam logic [11:0]   COLS_A   = 12'(COLS);

  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  logic          r_raw_vis;
  logic          r_raw_hs;
  logic          r_raw_vs;

  logic          w_vis;
  logic          w_hs;
  logic          w_vs;
  logic [11:0]   w_addr;

  always_comb begin
    w_vis  = (r_hcount < H_VIS_C) && (r_vcount < V_VIS_C);
    w_hs   = !((r_hcount >= H_SS) && (r_hcount < H_SE));
    w_vs   = !((r_vcount >= V_SS) && (r_vcount < V_SE));
    w_addr = 12'(r_vcount / CELL_H_V) * COLS_A + 12'(r_hcount / CELL_W_H);
  end

  // Stage 1 captures address and timing flags for the current position; stage 2 pairs
  // those flags with the memory data that arrived in the meantime.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_raw_vis   <= 1'b0;
      r_raw_hs    <= 1'b1;
      r_raw_vs    <= 1'b1;
      oRamAddress <= '0;
      oRed        <= 1'b0;
      oGreen      <= 1'b0;
      oBlue       <= 1'b0;
      oHSync      <= 1'b1;
      oVSync      <= 1'b1;
      oVisible    <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      oFrameStart <= 1'b0;
      if (iPixelTick) begin
        if (r_hcount == H_LAST) begin
          r_hcount <= '0;
          if (r_vcount == V_LAST) begin
            r_vcount    <= '0;
            oFrameStart <= 1'b1;
          end else begin
            r_vcount <= r_vcount + 1'b1;
          end
        end else begin
          r_hcount <= r_hcount + 1'b1;
        end

        oRamAddress <= w_vis ? w_addr : '0;
        r_raw_vis   <= w_vis;
        r_raw_hs    <= w_hs;
        r_raw_vs    <= w_vs;

        oRed     <= r_raw_vis & iRamData[2];
        oGreen   <= r_raw_vis & iRamData[1];
        oBlue    <= r_raw_vis & iRamData[0];
        oHSync   <= r_raw_hs;
        oVSync   <= r_raw_vs;
        oVisible <= r_raw_vis;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout using reduced timing so a full frame fits in a short run.
module tb_vga_scanout;

  localparam int HV = 96, HF = 8, HS = 16, HB = 8;
  localparam int VV = 32, VF = 3, VS = 2, VB = 4;
  localparam int CW = 16, CH = 8, NCOLS = HV / CW;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct {
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        vis;
    logic [11:0] addr;
    logic        wrap;
  } exp_t;

  localparam exp_t RST_EXP = '{rgb: 3'b000, hs: 1'b1, vs: 1'b1, vis: 1'b0, addr: 12'd0, wrap: 1'b0};

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iPixelTick;
  logic [11:0] oRamAddress;
  logic [2:0]  iRamData = 3'b000;
  logic        oRed, oGreen, oBlue, oHSync, oVSync, oVisible, oFrameStart;

  logic [2:0]  mem [4096];
  exp_t        q[$];
  exp_t        cur;
  logic [11:0] addr_exp;
  logic        fs_exp;
  logic        mon_ticked;
  int          p;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_frames = 0;
  int          obs_frames = 0;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CELL_W(CW), .CELL_H(CH), .COLS(NCOLS)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iPixelTick(iPixelTick),
    .oRamAddress(oRamAddress), .iRamData(iRamData),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oHSync(oHSync), .oVSync(oVSync), .oVisible(oVisible),
    .oFrameStart(oFrameStart)
  );

  always #5 Clock = ~Clock;

  // Video memory: data for the address presented at one edge appears after the next edge.
  always @(posedge Clock) iRamData <= mem[oRamAddress];

  // Expected response for scan position p, computed straight from the timing rules.
  function automatic exp_t model(int pos);
    exp_t e;
    int h, v;
    h = pos % HT;
    v = pos / HT;
    e.vis  = (h < HV) && (v < VV);
    e.addr = e.vis ? 12'((v / CH) * NCOLS + h / CW) : 12'd0;
    e.rgb  = e.vis ? mem[e.addr] : 3'b000;
    e.hs   = !((h >= HV + HF) && (h < HV + HF + HS));
    e.vs   = !((v >= VV + VF) && (v < VV + VF + VS));
    e.wrap = (pos == FRAME - 1);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    iPixelTick = 1'b1;
    q.push_back(model(p));
    if (p == FRAME - 1) begin
      exp_frames++;
      p = 0;
    end else begin
      p++;
    end
    @(negedge Clock);
    iPixelTick = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge Clock);
  endtask

  task automatic run_to(input int target);
    while (p != target) tick();
  endtask

  // Monitor: after every clock, retire scoreboard entries whose colour is now on the outputs.
  always @(posedge Clock) begin
    mon_ticked = iPixelTick & Reset;
    #1;
    if (mon_ticked) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: got empty queue expected pending entry at t=%0t", $time);
      end else begin
        addr_exp = q[$].addr;
        fs_exp   = q[$].wrap;
        while (q.size() > 1) cur = q.pop_front();
      end
    end else begin
      fs_exp = 1'b0;
    end
    check("pixel", 32'({oRed, oGreen, oBlue, oHSync, oVSync, oVisible}),
          32'({cur.rgb, cur.hs, cur.vs, cur.vis}));
    check("addr", 32'(oRamAddress), 32'(addr_exp));
    check("fstart", 32'(oFrameStart), 32'(fs_exp));
    if (oFrameStart === 1'b1) obs_frames++;
  end

  initial begin
    Reset      = 1'b0;
    iPixelTick = 1'b0;
    cur        = RST_EXP;
    addr_exp   = '0;
    fs_exp     = 1'b0;
    p          = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 3'($urandom);
    mem[0] = 3'b010;
    repeat (3) @(negedge Clock);
    check("reset_state", 32'({oRed, oGreen, oBlue, oHSync, oVSync, oVisible, oFrameStart}),
          32'(7'b0001100));
    Reset = 1'b1;

    tick();
    tick();
    check("first_pixel", 32'({oRed, oGreen, oBlue, oVisible, oHSync, oVSync}), 32'(6'b010111));

    run_to(9 * HT + 17);
    tick();
    check("cell_addr", 32'(oRamAddress), 32'(NCOLS + 1));
    tick();
    check("cell_colour", 32'({oRed, oGreen, oBlue}), 32'(mem[NCOLS + 1]));

    run_to(10 * HT + 40);
    repeat (50) @(negedge Clock);
    mem[0] = 3'b111;

    run_to(FRAME - 1);
    tick();
    run_to(20 * HT + 50);

    @(negedge Clock);
    #2;
    Reset    = 1'b0;
    cur      = RST_EXP;
    addr_exp = '0;
    fs_exp   = 1'b0;
    q.delete();
    p = 0;
    #1;
    check("async_reset", 32'({oRed, oGreen, oBlue, oHSync, oVSync, oVisible, oFrameStart, oRamAddress}),
          32'({7'b0001100, 12'd0}));
    mem[0] = 3'b101;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    tick();
    tick();
    check("restart_pixel", 32'({oRed, oGreen, oBlue, oVisible}), 32'(4'b1011));

    run_to(3 * HT + 10);
    repeat (4) @(negedge Clock);
    check("frame_pulses", 32'(obs_frames), 32'(exp_frames));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
